esm_slot_scheduler: RTL and testbench

- Allocation scheduler for the ESM buffer pool of `bs` slots.
- Tracks which slots are free in a bitmap and serves one requester through a req/gnt handshake.
- Picks a free slot by a rotating priority search. The search start offset comes from a free-running LFSR (random mode) or a round-robin pointer (optional).
- Accepts slot releases from the consumer. Exports the free bitmap as `ready_positions` for the ESM core.

---
 rtl/esm_slot_scheduler.sv | 123 ++++++++++++
 tb/tb_esm_slot_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/esm_slot_scheduler.sv
// ESM buffer-pool slot allocator: free bitmap, rotating-priority pick (LFSR offset, or rr_ptr with ESM_ROUND_ROBIN_EN).
// Latency: alloc_req sampled in IDLE -> alloc_gnt two edges later; at most one grant per 3 cycles.
// Backpressure: alloc_req is ignored while no slot is free; releases are accepted every cycle.
module esm_slot_scheduler #(
    parameter int          bs   = 16,
    parameter logic [31:0] SEED = 32'hACE1_2B3D
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_req,
    output logic                  alloc_gnt,
    output logic [$clog2(bs)-1:0] alloc_idx,
    input  logic                  rel_valid,
    input  logic [$clog2(bs)-1:0] rel_idx,
    output logic [bs-1:0]         ready_positions,
    output logic [$clog2(bs):0]   free_count,
    output logic                  full,
    output logic                  err
);
    localparam int          IW        = $clog2(bs);
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SELECT = 2'd1;
    localparam logic [1:0] S_GRANT  = 2'd2;

    logic [1:0]    state;
    logic [bs-1:0] free_mask;
    logic [bs-1:0] mask_nxt;
    logic [31:0]   lfsr;
    logic [IW-1:0] offset;
    logic [IW-1:0] start_pos;
    logic [IW-1:0] sel_idx;
    logic [IW-1:0] cand;
    logic          found;

`ifdef ESM_ROUND_ROBIN_EN
    logic [IW-1:0] rr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (state == S_GRANT) begin
            rr_ptr <= alloc_idx + 1'b1;
        end
    end

    assign start_pos = rr_ptr;
`else
    assign start_pos = lfsr[IW-1:0];
`endif

    assign alloc_gnt       = (state == S_GRANT);
    assign ready_positions = free_mask;
    assign full            = ~|free_mask;

    always_comb begin
        free_count = '0;
        for (int i = 0; i < bs; i++) begin
            free_count = free_count + (IW+1)'(free_mask[i]);
        end
    end

    // First free slot at offset, offset+1, ... wrapping; index arithmetic wraps since bs is a power of two.
    always_comb begin
        sel_idx = offset;
        cand    = offset;
        found   = 1'b0;
        for (int i = 0; i < bs; i++) begin
            cand = offset + IW'(i);
            if (!found && free_mask[cand]) begin
                sel_idx = cand;
                found   = 1'b1;
            end
        end
    end

    // A release of an already-free slot (including the one being granted) never touches the mask.
    always_comb begin
        mask_nxt = free_mask;
        if (rel_valid && !free_mask[rel_idx]) begin
            mask_nxt[rel_idx] = 1'b1;
        end
        if (state == S_GRANT) begin
            mask_nxt[alloc_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            free_mask <= '1;
            lfsr      <= SEED;
            offset    <= '0;
            alloc_idx <= '0;
            err       <= 1'b0;
        end else begin
            lfsr      <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
            free_mask <= mask_nxt;
            if (rel_valid && free_mask[rel_idx]) begin
                err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (alloc_req && (|free_mask)) begin
                        offset <= start_pos;
                        state  <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    alloc_idx <= sel_idx;
                    state     <= S_GRANT;
                end
                S_GRANT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_esm_slot_scheduler.sv
// Scoreboarded bench for esm_slot_scheduler: reference model predicts grants and the free bitmap.
module tb_esm_slot_scheduler;
    localparam int          BS   = 16;
    localparam int          IW   = 4;
    localparam logic [31:0] SEED = 32'hACE1_2B3D;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alloc_req = 1'b0;
    logic          rel_valid = 1'b0;
    logic [IW-1:0] rel_idx = '0;
    logic          alloc_gnt;
    logic [IW-1:0] alloc_idx;
    logic [BS-1:0] ready_positions;
    logic [IW:0]   free_count;
    logic          full;
    logic          err;

    esm_slot_scheduler #(.bs(BS), .SEED(SEED)) dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_idx(alloc_idx),
        .rel_valid(rel_valid), .rel_idx(rel_idx),
        .ready_positions(ready_positions), .free_count(free_count),
        .full(full), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int gnt_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: a request is taken in an idle cycle, the search runs on the mask of the
    // following cycle, and the grant cycle after that removes the slot.
    logic [31:0]   m_lfsr;
    logic [BS-1:0] m_mask;
    logic [BS-1:0] m_pre;
    logic          m_err;
    int            m_stage;
    int            m_off;
    int            m_gidx;
    int            m_rr;
    int            exp_q[$];

    function automatic int first_free(input logic [BS-1:0] mask, input int off);
        int s;
        for (int k = 0; k < BS; k++) begin
            s = (off + k) % BS;
            if (mask[s[IW-1:0]]) return s;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr  = SEED;
            m_mask  = '1;
            m_err   = 1'b0;
            m_stage = 0;
            m_rr    = 0;
            m_gidx  = 0;
            exp_q.delete();
        end else begin
            m_pre = m_mask;
            if (rel_valid) begin
                if (m_pre[rel_idx]) m_err = 1'b1;
                else m_mask[rel_idx] = 1'b1;
            end
            if (m_stage == 2) begin
                m_mask[m_gidx[IW-1:0]] = 1'b0;
`ifdef ESM_ROUND_ROBIN_EN
                m_rr = (m_gidx + 1) % BS;
`endif
                m_stage = 0;
            end else if (m_stage == 1) begin
                m_gidx = first_free(m_pre, m_off);
                exp_q.push_back(m_gidx);
                m_stage = 2;
            end else if (alloc_req && m_pre != 0) begin
`ifdef ESM_ROUND_ROBIN_EN
                m_off = m_rr;
`else
                m_off = int'(m_lfsr[IW-1:0]);
`endif
                m_stage = 1;
            end
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h8020_0003) : (m_lfsr >> 1);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("alloc_gnt", alloc_gnt, m_stage == 2);
            if (alloc_gnt) begin
                gnt_cnt++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL gnt_unexpected: got grant idx %0d, expected no grant", alloc_idx);
                end else begin
                    chk("alloc_idx", alloc_idx, exp_q.pop_front());
                end
                chk("granted_slot_was_free", ready_positions[alloc_idx], 1);
            end
            chk("ready_positions", ready_positions, m_mask);
            chk("free_count", free_count, $countones(m_mask));
            chk("full", full, m_mask == 0);
            chk("err", err, m_err);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic release_slot(input int idx);
        @(negedge clk);
        rel_valid = 1'b1;
        rel_idx   = idx[IW-1:0];
        @(negedge clk);
        rel_valid = 1'b0;
    endtask

    task automatic wait_gnt(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (alloc_gnt) return;
        end
        n_chk++;
        $display("FAIL %s: no alloc_gnt within %0d cycles, expected one", name, budget);
    endtask

    initial begin
        int start_cnt;
        bit seen;

        cyc(2);
        rst = 1'b0;
        #1;
        chk("reset_ready_positions", ready_positions, 16'hFFFF);
        chk("reset_free_count", free_count, 16);
        chk("reset_full", full, 0);
        chk("reset_err", err, 0);
        chk("reset_alloc_gnt", alloc_gnt, 0);
        chk("reset_alloc_idx", alloc_idx, 0);

        // Drain: request held high until the pool is empty.
        @(negedge clk);
        alloc_req = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_mask == 0 && m_stage == 0) break;
        end
        cyc(6);
        chk("drain_full", full, 1);
        chk("drain_free_count", free_count, 0);
        chk("drain_grant_total", gnt_cnt, 16);

        // Refill from full with the request still pending.
        release_slot(5);
        chk("refill_mask", ready_positions, 16'h0020);
        wait_gnt("refill_grant", 10);
        chk("refill_idx", alloc_idx, 5);
        alloc_req = 1'b0;
        @(negedge clk);
        chk("refill_mask_empty", ready_positions, 16'h0000);

        // Release of another allocated slot during the grant of slot 7.
        release_slot(7);
        alloc_req = 1'b1;
        wait_gnt("grant7", 10);
        chk("grant7_idx", alloc_idx, 7);
        rel_valid = 1'b1;
        rel_idx   = 4'd2;
        alloc_req = 1'b0;
        @(negedge clk);
        rel_valid = 1'b0;
        chk("simul_release_mask", ready_positions, 16'h0004);
        chk("simul_release_err", err, 0);

        // Releasing slot 3 twice: the second is a release of a free slot.
        release_slot(3);
        chk("err_after_valid_release", err, 0);
        release_slot(3);
        chk("err_set", err, 1);
        cyc(3);
        chk("err_sticky", err, 1);

        // Reset while the search is in progress.
        alloc_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_stage == 1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("reached_select", seen, 1);
        #2 rst = 1'b1;
        #1;
        chk("midop_ready_positions", ready_positions, 16'hFFFF);
        chk("midop_alloc_gnt", alloc_gnt, 0);
        chk("midop_err", err, 0);
        alloc_req = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        cyc(4);
        chk("post_reset_free_count", free_count, 16);

        // Random traffic: LFSR restarted from SEED, model predicts every index.
        start_cnt = gnt_cnt;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (gnt_cnt - start_cnt >= 200) break;
            alloc_req = ($urandom_range(0, 7) != 0);
            rel_valid = ($urandom_range(0, 2) == 0);
            rel_idx   = IW'($urandom_range(0, BS - 1));
        end
        alloc_req = 1'b0;
        rel_valid = 1'b0;
        cyc(6);
        chk("random_grant_count", (gnt_cnt - start_cnt) >= 200, 1);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
